// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm -- multicycle main control unit for the MIPS core.
//
// Moore FSM that sequences the shared-ALU / unified-memory datapath through
// fetch, decode and per-class execute/writeback states. It supports
// load/store, register-register, BEQ/BNE, immediate ALU and J instructions.
// It also provides a variable-latency memory handshake, an illegal-opcode
// trap and a retired-instruction counter.
//
// Parameters
//   MEM_HANDSHAKE : 1 = memory states wait for mem_ready
//                   0 = every memory access completes in one cycle
//   TRAP_EN       : 1 = an illegal opcode enters the sticky Trap state
//                   0 = an illegal opcode pulses illegal in Decode, then
//                       returns to Fetch
//   CNT_W         : width of the retired-instruction counter
//
// Ports
//   clk, reset       : clock and asynchronous active-high reset
//   opcode           : IR[31:26], stable from Decode until the return to Fetch
//   mem_ready        : memory completes the current read/write this cycle
//   mem_rd, mem_wr   : memory read / write request
//   iord             : memory address select (0 = PC, 1 = ALUout)
//   ir_wr            : instruction register load
//   pc_wr            : unconditional PC write
//   branch           : conditional PC write
//   branch_ne        : branch polarity (1 = write PC on not-zero)
//   pc_src           : 0 = ALU result, 1 = ALUout, 2 = jump target
//   alu_srca         : 0 = PC, 1 = rs
//   alu_srcb         : 0 = rt, 1 = 4, 2 = imm, 3 = imm<<2
//   imm_zext         : zero-extend the immediate
//   alu_op           : ADD=0 SUB=1 ADDU=2 AND=3 OR=4 XOR=5 RR=6
//   reg_dst          : destination register select (0 = rt, 1 = rd)
//   mem_to_reg       : writeback source select (0 = ALUout, 1 = memory)
//   reg_wr           : register file write enable
//   illegal          : illegal-opcode indication
//   state            : current state (debug)
//   retired          : retired-instruction count, wraps at 2^CNT_W
module mc_ctrl_fsm #(
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter bit TRAP_EN       = 1'b1,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             iord,
    output logic             ir_wr,
    output logic             pc_wr,
    output logic             branch,
    output logic             branch_ne,
    output logic [1:0]       pc_src,
    output logic             alu_srca,
    output logic [1:0]       alu_srcb,
    output logic             imm_zext,
    output logic [3:0]       alu_op,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_wr,
    output logic             illegal,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADDR  = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWRBCK = 4'd4,
        S_MEMWR    = 4'd5,
        S_RREXEC   = 4'd6,
        S_RRWRBCK  = 4'd7,
        S_BREXEC   = 4'd8,
        S_IMMEXEC  = 4'd9,
        S_IMMWRBCK = 4'd10,
        S_JEXEC    = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    localparam logic [5:0] OP_RR    = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_ADDU = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_RR   = 4'd6;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    logic       rdy;
    logic       retire;
    logic       mem_rd_s, mem_wr_s, ir_wr_s, pc_wr_s, branch_s, reg_wr_s;
    logic       illegal_s;

    // Without the handshake every memory access is treated as completing
    // in the cycle it is issued.
    assign rdy = MEM_HANDSHAKE ? mem_ready : 1'b1;

    always_comb begin
        state_d    = state_q;
        retire     = 1'b0;
        mem_rd_s   = 1'b0;
        mem_wr_s   = 1'b0;
        ir_wr_s    = 1'b0;
        pc_wr_s    = 1'b0;
        branch_s   = 1'b0;
        reg_wr_s   = 1'b0;
        illegal_s  = 1'b0;
        iord       = 1'b0;
        branch_ne  = 1'b0;
        pc_src     = 2'd0;
        alu_srca   = 1'b0;
        alu_srcb   = 2'd0;
        imm_zext   = 1'b0;
        alu_op     = ALU_ADD;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;

        case (state_q)
            S_FETCH: begin
                // The read request stays up while waiting. IR and PC load
                // only in the cycle the memory actually delivers.
                mem_rd_s = 1'b1;
                alu_srcb = 2'd1;
                ir_wr_s  = rdy;
                pc_wr_s  = rdy;
                if (rdy) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                // The ALU precomputes the branch target (PC + imm<<2)
                // while the opcode is being decoded.
                alu_srcb = 2'd3;
                case (opcode)
                    OP_LW, OP_SW:   state_d = S_MEMADDR;
                    OP_RR:          state_d = S_RREXEC;
                    OP_BEQ, OP_BNE: state_d = S_BREXEC;
                    OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI:
                                    state_d = S_IMMEXEC;
                    OP_J:           state_d = S_JEXEC;
                    default: begin
                        if (TRAP_EN) begin
                            state_d = S_TRAP;
                        end else begin
                            // Non-trapping illegal opcode: flag it for this
                            // cycle only. It is not counted as retired.
                            state_d   = S_FETCH;
                            illegal_s = 1'b1;
                        end
                    end
                endcase
            end
            S_MEMADDR: begin
                alu_srca = 1'b1;
                alu_srcb = 2'd2;
                state_d  = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_rd_s = 1'b1;
                iord     = 1'b1;
                if (rdy) begin
                    state_d = S_MEMWRBCK;
                end
            end
            S_MEMWRBCK: begin
                reg_wr_s   = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = S_FETCH;
                retire     = 1'b1;
            end
            S_MEMWR: begin
                mem_wr_s = 1'b1;
                iord     = 1'b1;
                if (rdy) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_RREXEC: begin
                alu_srca = 1'b1;
                alu_op   = ALU_RR;
                state_d  = S_RRWRBCK;
            end
            S_RRWRBCK: begin
                reg_wr_s = 1'b1;
                reg_dst  = 1'b1;
                state_d  = S_FETCH;
                retire   = 1'b1;
            end
            S_BREXEC: begin
                alu_srca  = 1'b1;
                alu_op    = ALU_SUB;
                branch_s  = 1'b1;
                pc_src    = 2'd1;
                branch_ne = (opcode == OP_BNE);
                state_d   = S_FETCH;
                retire    = 1'b1;
            end
            S_IMMEXEC: begin
                alu_srca = 1'b1;
                alu_srcb = 2'd2;
                case (opcode)
                    OP_ADDIU: alu_op = ALU_ADDU;
                    OP_ANDI:  begin alu_op = ALU_AND; imm_zext = 1'b1; end
                    OP_ORI:   begin alu_op = ALU_OR;  imm_zext = 1'b1; end
                    OP_XORI:  begin alu_op = ALU_XOR; imm_zext = 1'b1; end
                    default:  alu_op = ALU_ADD;
                endcase
                state_d = S_IMMWRBCK;
            end
            S_IMMWRBCK: begin
                reg_wr_s = 1'b1;
                state_d  = S_FETCH;
                retire   = 1'b1;
            end
            S_JEXEC: begin
                pc_wr_s = 1'b1;
                pc_src  = 2'd2;
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_TRAP: begin
                // Sticky: only reset leaves this state.
                illegal_s = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_comb begin
        retired_d = retired_q;
        if (retire) begin
            retired_d = retired_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    // Side-effecting strobes are gated directly by reset. This lets an
    // in-flight write drop in the same instant reset rises, rather than at
    // the next clock edge.
    assign mem_rd  = mem_rd_s  & ~reset;
    assign mem_wr  = mem_wr_s  & ~reset;
    assign ir_wr   = ir_wr_s   & ~reset;
    assign pc_wr   = pc_wr_s   & ~reset;
    assign branch  = branch_s  & ~reset;
    assign reg_wr  = reg_wr_s  & ~reset;
    assign illegal = illegal_s & ~reset;
    assign state   = state_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Testbench for mc_ctrl_fsm.
//
// There are two instances. Instance A uses the default configuration
// (handshake, trap, 32-bit counter). Instance B uses no handshake, no trap
// and a 4-bit counter. Both instances see the same stimulus, and `sel`
// picks which one the monitor checks.
//
// For every cycle it drives, the stimulus pushes the expected state,
// control vector and retired count into a queue. A reference model derives
// these from the instruction class and the per-state output table. The
// monitor pops one entry at each falling edge, or at an explicit async
// sample event, and compares it against the selected instance.
module tb_mc_ctrl_fsm;

    typedef struct packed {
        logic       mem_rd;
        logic       mem_wr;
        logic       iord;
        logic       ir_wr;
        logic       pc_wr;
        logic       branch;
        logic       branch_ne;
        logic [1:0] pc_src;
        logic       alu_srca;
        logic [1:0] alu_srcb;
        logic       imm_zext;
        logic [3:0] alu_op;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_wr;
        logic       illegal;
    } ctrl_t;

    typedef struct {
        logic [3:0]  st;
        ctrl_t       c;
        logic [31:0] ret;
        string       tag;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'h00;
    logic       mem_ready = 1'b0;
    logic       sel = 1'b0;

    always #5 clk = ~clk;

    logic       a_mem_rd, a_mem_wr, a_iord, a_ir_wr, a_pc_wr, a_branch, a_branch_ne;
    logic       a_alu_srca, a_imm_zext, a_reg_dst, a_mem_to_reg, a_reg_wr, a_illegal;
    logic [1:0] a_pc_src, a_alu_srcb;
    logic [3:0] a_alu_op, a_state;
    logic [31:0] a_retired;

    logic       b_mem_rd, b_mem_wr, b_iord, b_ir_wr, b_pc_wr, b_branch, b_branch_ne;
    logic       b_alu_srca, b_imm_zext, b_reg_dst, b_mem_to_reg, b_reg_wr, b_illegal;
    logic [1:0] b_pc_src, b_alu_srcb;
    logic [3:0] b_alu_op, b_state;
    logic [3:0] b_retired;

    mc_ctrl_fsm #(.MEM_HANDSHAKE(1'b1), .TRAP_EN(1'b1), .CNT_W(32)) dut_a (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .mem_rd(a_mem_rd), .mem_wr(a_mem_wr), .iord(a_iord), .ir_wr(a_ir_wr),
        .pc_wr(a_pc_wr), .branch(a_branch), .branch_ne(a_branch_ne),
        .pc_src(a_pc_src), .alu_srca(a_alu_srca), .alu_srcb(a_alu_srcb),
        .imm_zext(a_imm_zext), .alu_op(a_alu_op), .reg_dst(a_reg_dst),
        .mem_to_reg(a_mem_to_reg), .reg_wr(a_reg_wr), .illegal(a_illegal),
        .state(a_state), .retired(a_retired)
    );

    mc_ctrl_fsm #(.MEM_HANDSHAKE(1'b0), .TRAP_EN(1'b0), .CNT_W(4)) dut_b (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .mem_rd(b_mem_rd), .mem_wr(b_mem_wr), .iord(b_iord), .ir_wr(b_ir_wr),
        .pc_wr(b_pc_wr), .branch(b_branch), .branch_ne(b_branch_ne),
        .pc_src(b_pc_src), .alu_srca(b_alu_srca), .alu_srcb(b_alu_srcb),
        .imm_zext(b_imm_zext), .alu_op(b_alu_op), .reg_dst(b_reg_dst),
        .mem_to_reg(b_mem_to_reg), .reg_wr(b_reg_wr), .illegal(b_illegal),
        .state(b_state), .retired(b_retired)
    );

    ctrl_t       a_c, b_c, obs_c;
    logic [3:0]  obs_st;
    logic [31:0] obs_ret;

    assign a_c = {a_mem_rd, a_mem_wr, a_iord, a_ir_wr, a_pc_wr, a_branch, a_branch_ne,
                  a_pc_src, a_alu_srca, a_alu_srcb, a_imm_zext, a_alu_op,
                  a_reg_dst, a_mem_to_reg, a_reg_wr, a_illegal};
    assign b_c = {b_mem_rd, b_mem_wr, b_iord, b_ir_wr, b_pc_wr, b_branch, b_branch_ne,
                  b_pc_src, b_alu_srca, b_alu_srcb, b_imm_zext, b_alu_op,
                  b_reg_dst, b_mem_to_reg, b_reg_wr, b_illegal};
    assign obs_c   = sel ? b_c : a_c;
    assign obs_st  = sel ? b_state : a_state;
    assign obs_ret = sel ? {28'd0, b_retired} : a_retired;

    // Configuration of the instance currently being checked.
    bit          cfg_hs   = 1'b1;
    bit          cfg_trap = 1'b1;
    int          cfg_w    = 32;
    logic [31:0] ret_model = '0;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    event async_ev;

    logic [5:0] legal_ops [11] = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h05, 6'h08,
                                   6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h02};

    function automatic bit is_legal(input logic [5:0] op);
        foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    // Expected outputs for one cycle in state `st`, given the output table
    // for each state.
    function automatic ctrl_t model_ctrl(input int st, input logic [5:0] op,
                                         input bit rdy, input bit rst);
        ctrl_t c;
        c = '0;
        case (st)
            0:  begin c.mem_rd = 1'b1; c.alu_srcb = 2'd1; c.ir_wr = rdy; c.pc_wr = rdy; end
            1:  begin c.alu_srcb = 2'd3; c.illegal = !cfg_trap && !is_legal(op); end
            2:  begin c.alu_srca = 1'b1; c.alu_srcb = 2'd2; end
            3:  begin c.mem_rd = 1'b1; c.iord = 1'b1; end
            4:  begin c.reg_wr = 1'b1; c.mem_to_reg = 1'b1; end
            5:  begin c.mem_wr = 1'b1; c.iord = 1'b1; end
            6:  begin c.alu_srca = 1'b1; c.alu_op = 4'd6; end
            7:  begin c.reg_wr = 1'b1; c.reg_dst = 1'b1; end
            8:  begin c.alu_srca = 1'b1; c.alu_op = 4'd1; c.branch = 1'b1;
                      c.pc_src = 2'd1; c.branch_ne = (op == 6'h05); end
            9:  begin
                    c.alu_srca = 1'b1; c.alu_srcb = 2'd2;
                    case (op)
                        6'h09: c.alu_op = 4'd2;
                        6'h0C: begin c.alu_op = 4'd3; c.imm_zext = 1'b1; end
                        6'h0D: begin c.alu_op = 4'd4; c.imm_zext = 1'b1; end
                        6'h0E: begin c.alu_op = 4'd5; c.imm_zext = 1'b1; end
                        default: c.alu_op = 4'd0;
                    endcase
                end
            10: c.reg_wr = 1'b1;
            11: begin c.pc_wr = 1'b1; c.pc_src = 2'd2; end
            12: c.illegal = 1'b1;
            default: c = '0;
        endcase
        if (rst) begin
            c.mem_rd = 1'b0; c.mem_wr = 1'b0; c.ir_wr = 1'b0; c.pc_wr = 1'b0;
            c.branch = 1'b0; c.reg_wr = 1'b0; c.illegal = 1'b0;
        end
        return c;
    endfunction

    task automatic push_exp(input int st, input bit rdy, input bit rst, input string tag);
        exp_t e;
        e.st  = 4'(st);
        e.c   = model_ctrl(st, opcode, rdy, rst);
        e.ret = rst ? 32'd0 : ret_model;
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    // One clock cycle in state `st`. rd: 0/1 drive mem_ready, 2 = random
    // (value must not matter to the DUT).
    task automatic cyc(input int st, input int rd, input string tag);
        bit drv;
        drv = (rd == 2) ? 1'($urandom_range(0, 1)) : 1'(rd);
        mem_ready = drv;
        push_exp(st, cfg_hs ? drv : 1'b1, 1'b0, tag);
        @(posedge clk); #1;
    endtask

    task automatic retire_model();
        ret_model = ret_model + 32'd1;
        if (cfg_w < 32) ret_model = ret_model & ((32'd1 << cfg_w) - 32'd1);
    endtask

    // Runs one whole instruction. fw/mw are the mem_ready-low cycles in
    // Fetch and in the data memory state (handshake config only).
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
        string tag;
        tag = $sformatf("op%02h", op);
        opcode = op;
        if (cfg_hs) begin
            repeat (fw) cyc(0, 0, tag);
            cyc(0, 1, tag);
        end else begin
            cyc(0, 2, tag);
        end
        cyc(1, 2, tag);
        case (op)
            6'h23: begin
                cyc(2, 2, tag);
                if (cfg_hs) begin repeat (mw) cyc(3, 0, tag); cyc(3, 1, tag); end
                else cyc(3, 2, tag);
                cyc(4, 2, tag);
                retire_model();
            end
            6'h2B: begin
                cyc(2, 2, tag);
                if (cfg_hs) begin repeat (mw) cyc(5, 0, tag); cyc(5, 1, tag); end
                else cyc(5, 2, tag);
                retire_model();
            end
            6'h00:         begin cyc(6, 2, tag); cyc(7, 2, tag); retire_model(); end
            6'h04, 6'h05:  begin cyc(8, 2, tag); retire_model(); end
            6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E:
                           begin cyc(9, 2, tag); cyc(10, 2, tag); retire_model(); end
            6'h02:         begin cyc(11, 2, tag); retire_model(); end
            default: if (cfg_trap) repeat (10) cyc(12, 2, tag);
        endcase
        $display("instr dut=%s op=%02h fetch_wait=%0d mem_wait=%0d retired_exp=%0d",
                 sel ? "B" : "A", op, fw, mw, ret_model);
    endtask

    task automatic hard_reset();
        reset = 1'b1;
        mem_ready = 1'b0;
        ret_model = '0;
        push_exp(0, 1'b0, 1'b1, "reset");
        @(posedge clk); #1;
        push_exp(0, 1'b0, 1'b1, "reset");
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Checks the current state once more, then raises reset mid-cycle and
    // samples immediately, before any clock edge.
    task automatic async_reset(input int st_now, input string tag);
        mem_ready = 1'b0;
        push_exp(st_now, 1'b0, 1'b0, tag);
        @(negedge clk); #1;
        reset = 1'b1;
        ret_model = '0;
        #1;
        push_exp(0, 1'b0, 1'b1, {tag, "_async_rst"});
        -> async_ev;
        @(posedge clk); #1;
        push_exp(0, 1'b0, 1'b1, {tag, "_rst"});
        @(posedge clk); #1;
        reset = 1'b0;
        $display("async reset during state %0d (%s)", st_now, tag);
    endtask

    // Monitor: one expected entry per falling edge or async sample event.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or async_ev);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (obs_st !== e.st) begin
                    errors++;
                    $display("FAIL %s state: got=%0d exp=%0d", e.tag, obs_st, e.st);
                end
                checks++;
                if (obs_c !== e.c) begin
                    errors++;
                    $display("FAIL %s ctrl (st %0d): got=%06h exp=%06h",
                             e.tag, e.st, obs_c, e.c);
                end
                checks++;
                if (obs_ret !== e.ret) begin
                    errors++;
                    $display("FAIL %s retired (st %0d): got=%0d exp=%0d",
                             e.tag, e.st, obs_ret, e.ret);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [5:0] op;
        @(posedge clk); #1;

        // ---------------- Instance A: handshake, trap, 32-bit counter
        sel = 1'b0; cfg_hs = 1'b1; cfg_trap = 1'b1; cfg_w = 32;
        hard_reset();
        run_instr(6'h23, 0, 0);             // LW, ready immediately
        run_instr(6'h2B, 0, 3);             // SW with 3 wait cycles
        run_instr(6'h00, 0, 0);             // RR
        run_instr(6'h04, 0, 0);             // BEQ
        run_instr(6'h05, 0, 0);             // BNE
        run_instr(6'h02, 0, 0);             // J
        run_instr(6'h0D, 0, 0);             // ORI
        run_instr(6'h08, 0, 0);             // ADDI
        run_instr(6'h00, 2, 0);             // fetch waits 2 cycles
        repeat (40) begin
            op = legal_ops[$urandom_range(0, 10)];
            run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3));
        end

        // Reset while a store is waiting for memory.
        opcode = 6'h2B;
        cyc(0, 1, "sw_abort"); cyc(1, 2, "sw_abort"); cyc(2, 2, "sw_abort");
        cyc(5, 0, "sw_abort"); cyc(5, 0, "sw_abort");
        async_reset(5, "sw_abort");
        run_instr(6'h23, 1, 1);

        // Illegal opcode: sticky trap, then reset out of it.
        run_instr(6'h3F, 0, 0);
        async_reset(12, "trap");
        run_instr(6'h02, 0, 0);

        // ---------------- Instance B: no handshake, no trap, 4-bit counter
        @(negedge clk); #1;
        sel = 1'b1; cfg_hs = 1'b0; cfg_trap = 1'b0; cfg_w = 4;
        @(posedge clk); #1;
        hard_reset();
        run_instr(6'h3F, 0, 0);             // illegal pulse, no retire
        repeat (17) run_instr(6'h00, 0, 0); // counter wraps to 1
        run_instr(6'h02, 0, 0);
        repeat (30) begin
            if ($urandom_range(0, 3) == 0) op = 6'($urandom_range(0, 63));
            else op = legal_ops[$urandom_range(0, 10)];
            run_instr(op, 0, 0);
        end

        @(posedge clk); #1;
        @(negedge clk); #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got=%0d pending exp=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
Parametrised multicycle main control unit for the MIPS core; successor to the fixed 8-state controller. Adds immediate-ALU, BNE and J paths, a variable-latency memory handshake, an illegal-opcode trap and a retired-instruction counter. Sits between the instruction register (opcode field) and the datapath muxes, register file, PC and unified memory.

Parameters:
MEM_HANDSHAKE, 1, 1: memory states wait for mem_ready; 0: mem_ready ignored, memory accesses take one cycle
TRAP_EN, 1, 1: illegal opcode enters sticky Trap; 0: illegal opcode pulses illegal for one cycle, returns to Fetch
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  clock
reset  in  1  asynchronous reset, active-high
opcode  in  6  IR[31:26], stable from Decode until return to Fetch
mem_ready  in  1  memory completes current read/write this cycle
mem_rd  out  1  memory read request
mem_wr  out  1  memory write request
iord  out  1  memory address select: 0 = PC, 1 = ALUout
ir_wr  out  1  instruction register load
pc_wr  out  1  unconditional PC write
branch  out  1  conditional PC write (BEQ/BNE)
branch_ne  out  1  condition polarity: 1 = write on not-zero
pc_src  out  2  0 = ALU result, 1 = ALUout, 2 = jump target
alu_srca  out  1  0 = PC, 1 = rs
alu_srcb  out  2  0 = rt, 1 = constant 4, 2 = imm, 3 = imm<<2
imm_zext  out  1  1 = zero-extend imm, else sign-extend
alu_op  out  4  ADD=0, SUB=1, ADDU=2, AND=3, OR=4, XOR=5, RR=6 (funct decode)
reg_dst  out  1  0 = rt, 1 = rd
mem_to_reg  out  1  0 = ALUout, 1 = memory data
reg_wr  out  1  register file write
illegal  out  1  illegal-opcode indication
state  out  4  current state, debug
retired  out  CNT_W  retired instruction count

Behaviour:
- Moore FSM, one state register. Encoding: Fetch=0, Decode=1, MemAddr=2, MemRd=3, MemWrbck=4, MemWr=5, RRExec=6, RRWrbck=7, BrExec=8, ImmExec=9, ImmWrbck=10, JExec=11, Trap=12. Unlisted codes go to Fetch.
- Reset (async): state=Fetch, retired=0, illegal=0. While reset is high, mem_rd, mem_wr, ir_wr, pc_wr, branch and reg_wr are forced 0. All other outputs are 0 unless stated below.
- "rdy" means mem_ready when MEM_HANDSHAKE=1, constant 1 otherwise.
- Fetch: mem_rd=1, iord=0, alu_srca=0, alu_srcb=1, alu_op=ADD, pc_src=0, ir_wr=rdy, pc_wr=rdy. Moves to Decode on rdy, otherwise holds.
- Decode: alu_srca=0, alu_srcb=3, alu_op=ADD. Next state by opcode:
  - LW(23h)/SW(2Bh) -> MemAddr
  - RR(00h) -> RRExec
  - BEQ(04h)/BNE(05h) -> BrExec
  - ADDI(08h)/ADDIU(09h)/ANDI(0Ch)/ORI(0Dh)/XORI(0Eh) -> ImmExec
  - J(02h) -> JExec
  - other -> Trap if TRAP_EN, else Fetch with illegal=1 for this cycle
- MemAddr: alu_srca=1, alu_srcb=2, ADD. Goes to MemRd if LW, else MemWr.
- MemRd: mem_rd=1, iord=1. Moves to MemWrbck on rdy.
- MemWrbck: reg_wr=1, reg_dst=0, mem_to_reg=1. Goes to Fetch.
- MemWr: mem_wr=1, iord=1; held until rdy, then goes to Fetch.
- RRExec: alu_srca=1, alu_srcb=0, alu_op=RR. Goes to RRWrbck.
- RRWrbck: reg_wr=1, reg_dst=1, mem_to_reg=0. Goes to Fetch.
- BrExec: alu_srca=1, alu_srcb=0, SUB, branch=1, pc_src=1, branch_ne=(opcode==BNE). Goes to Fetch.
- ImmExec: alu_srca=1, alu_srcb=2. alu_op is ADD/ADDU/AND/OR/XOR for ADDI/ADDIU/ANDI/ORI/XORI. imm_zext=1 for ANDI/ORI/XORI. Goes to ImmWrbck.
- ImmWrbck: reg_wr=1, reg_dst=0, mem_to_reg=0. Goes to Fetch.
- JExec: pc_wr=1, pc_src=2. Goes to Fetch.
- Trap: illegal=1 and all write/request outputs 0. Stays in Trap until reset.
- retired increments by 1, wrapping at 2^CNT_W, on every transition into Fetch from MemWrbck, MemWr, RRWrbck, BrExec, ImmWrbck or JExec. The non-trap illegal path does not increment it.
- mem_ready is ignored outside Fetch, MemRd and MemWr.
- mem_rd/mem_wr stay asserted continuously while waiting; the memory may assert mem_ready in the first cycle of the request.
- Reset asserted mid-access drops mem_wr asynchronously. No partial retire is counted.

Test Plan:
- MEM_HANDSHAKE=1, mem_ready tied 1, LW -> states 0,1,2,3,4,0 (5 cycles); reg_wr=1 only in state 4; retired 0->1.
- SW with mem_ready low for 3 cycles in MemWr -> mem_wr high 4 cycles, state holds at 5, no reg_wr; retired +1 only on the ready cycle.
- Sequence RR, BEQ, BNE, J, ORI -> cycle counts 4,3,3,3,4; branch_ne=0/1 on BEQ/BNE; pc_src=2 in JExec; ORI gives alu_op=OR, imm_zext=1; ADDI gives imm_zext=0; retired=5.
- Fetch with mem_ready low 2 cycles -> ir_wr/pc_wr 0 until ready cycle, then 1 for exactly one cycle.
- Opcode 3Fh: TRAP_EN=1 -> state 12, illegal stays 1 across 10 cycles, mem_rd=0, retired unchanged. TRAP_EN=0 -> one-cycle illegal pulse, then Fetch.
- Reset asserted during MemWr wait and during Trap -> mem_wr and illegal fall immediately; after release state=0, retired=0. CNT_W=4 with 17 RR instructions -> retired=1.
